// File: rtl/bcd7_scan_driver.sv
// Time-multiplexed BCD-to-7-segment scan driver with ghost blanking, frame-boundary
// display update via a valid/ready load port, and leading-zero suppression.
// Define BCD7_SCAN_HEX_DIGITS_EN to decode values 10..15 as A,b,C,d,E,F instead of blank.
module bcd7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_full_q, pend_full_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;
  logic                    boundary;
  logic                    load_fire;
  logic [3:0]              digit_val;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
`ifdef BCD7_SCAN_HEX_DIGITS_EN
      4'd10:   seg_decode = 7'h77;
      4'd11:   seg_decode = 7'h7C;
      4'd12:   seg_decode = 7'h39;
      4'd13:   seg_decode = 7'h5E;
      4'd14:   seg_decode = 7'h79;
      default: seg_decode = 7'h71;
`else
      default: seg_decode = 7'h00;
`endif
    endcase
  endfunction

  // True when digit k and every more-significant digit are zero; digit 0 never qualifies.
  function automatic logic lz_blank(input logic [4*NUM_DIGITS-1:0] data,
                                    input logic [IDX_W-1:0] k);
    logic nonzero;
    nonzero = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(k) && data[4*j +: 4] != 4'd0) nonzero = 1'b1;
    end
    lz_blank = (k != '0) && !nonzero;
  endfunction

  assign load_fire = load_valid && !pend_full_q;
  assign digit_val = disp_data_q[4*idx_d +: 4];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    boundary     = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
    endcase

    // Display only swaps at the frame boundary so a frame is never torn.
    pend_full_d = pend_full_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    if (boundary && pend_full_q) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      pend_full_d = 1'b0;
    end
    if (load_fire) pend_full_d = 1'b1;
    pend_data_d = load_fire ? load_data : pend_data_q;
    pend_dp_d   = load_fire ? load_dp : pend_dp_q;

    seg_d        = 7'h00;
    dp_d         = 1'b0;
    an_d         = '0;
    frame_done_d = boundary;
    if (state_d == ST_DRIVE) begin
      an_d  = NUM_DIGITS'(1) << idx_d;
      dp_d  = disp_dp_q[idx_d];
      seg_d = (lz_en && lz_blank(disp_data_q, idx_d)) ? 7'h00 : seg_decode(digit_val);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      seg_q        <= 7'h00;
      dp_q         <= 1'b0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      pend_full_q  <= pend_full_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pending payload is qualified by pend_full, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_data_q <= pend_data_d;
    pend_dp_q   <= pend_dp_d;
  end

  assign load_ready = !pend_full_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd7_scan_driver.sv
// Self-checking bench for bcd7_scan_driver: directed and random loads checked every
// cycle against a frame-position reference model.
module tb_bcd7_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int BC    = 1;
  localparam int SLOT  = BC + SD;
  localparam int FRAME = ND * SLOT;

`ifdef BCD7_SCAN_HEX_DIGITS_EN
  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`else
  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
`endif

  logic            clk;
  logic            rst;
  logic            load_valid;
  logic            load_ready;
  logic [4*ND-1:0] load_data;
  logic [ND-1:0]   load_dp;
  logic            lz_en;
  logic [6:0]      seg;
  logic            dp;
  logic [ND-1:0]   an;
  logic            frame_done;

  bcd7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .lz_en(lz_en), .seg(seg), .dp(dp),
    .an(an), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: edges since reset release, shown and pending words.
  int              m_n;
  logic [4*ND-1:0] m_disp, m_pend;
  logic [ND-1:0]   m_ddp, m_pdp;
  bit              m_pend_full;
  logic [4*ND-1:0] q_data[$];
  logic [ND-1:0]   q_dp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, m_n);
    end
  endtask

  task automatic check_outputs();
    int q, d, digit;
    bit drive, sup;
    logic [6:0] e_seg;
    q     = m_n % FRAME;
    d     = q / SLOT;
    drive = (q % SLOT) >= BC;
    digit = int'((m_disp >> (4 * d)) & 16'hF);
    sup   = lz_en && d != 0 && (m_disp >> (4 * d)) == 0;
    e_seg = (drive && !sup) ? DEC[digit] : 7'h00;
    chk("an", 32'(an), drive ? (32'd1 << d) : 32'd0);
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(drive && m_ddp[d]));
    chk("frame_done", 32'(frame_done), 32'(m_n > 0 && q == 0));
    chk("load_ready", 32'(load_ready), 32'(!m_pend_full));
  endtask

  task automatic step();
    bit acc;
    if (q_data.size() > 0) begin
      load_valid = 1'b1;
      load_data  = q_data[0];
      load_dp    = q_dp[0];
    end else begin
      load_valid = 1'b0;
      load_data  = 16'($urandom);
      load_dp    = 4'($urandom);
    end
    @(posedge clk);
    acc = load_valid && !m_pend_full;
    m_n++;
    if (m_n % FRAME == 0 && m_pend_full) begin
      m_disp      = m_pend;
      m_ddp       = m_pdp;
      m_pend_full = 1'b0;
    end
    if (acc) begin
      m_pend      = q_data.pop_front();
      m_pdp       = q_dp.pop_front();
      m_pend_full = 1'b1;
    end
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_reset();
    m_n = 0; m_disp = '0; m_ddp = '0; m_pend = '0; m_pdp = '0; m_pend_full = 1'b0;
    q_data.delete();
    q_dp.delete();
  endtask

  function automatic logic [4*ND-1:0] rand_word();
    logic [4*ND-1:0] w;
    int r;
    w = '0;
    for (int k = 0; k < ND; k++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0) r = 0;
      if ($urandom_range(0, 9) == 0) r = $urandom_range(10, 15);
      w[4*k +: 4] = 4'(r);
    end
    return w;
  endfunction

  initial begin
    int guard;
    bit cond;
    rst = 1'b1; load_valid = 1'b0; load_data = '0; load_dp = '0; lz_en = 1'b0;
    model_reset();
    #3;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Idle frame showing zeros, then the first numeric load.
    run(FRAME);
    q_data.push_back(16'h1234); q_dp.push_back(4'b0100);
    run(2 * FRAME + 5);

    // Leading-zero suppression on and off.
    q_data.push_back(16'h0090); q_dp.push_back(4'b0000);
    lz_en = 1'b1;
    run(2 * FRAME);
    lz_en = 1'b0;
    run(FRAME);

    // Back-to-back loads; the second is held until the pending slot frees.
    q_data.push_back(16'h5678); q_dp.push_back(4'b0001);
    q_data.push_back(16'h9021); q_dp.push_back(4'b1000);
    run(3 * FRAME + 3);

    // Non-decimal digit value.
    q_data.push_back(16'h000B); q_dp.push_back(4'b0000);
    run(2 * FRAME);
    lz_en = 1'b1;
    run(FRAME);

    // Randomised loads with varying lz_en and gaps.
    for (int i = 0; i < 10; i++) begin
      q_data.push_back(rand_word());
      q_dp.push_back(4'($urandom));
      lz_en = 1'($urandom);
      run($urandom_range(5, 45));
    end
    run(3 * FRAME);

    // Asynchronous reset mid-drive of digit 2 with a pending word.
    lz_en = 1'b0;
    q_data.push_back(16'h4321); q_dp.push_back(4'b1111);
    guard = 0;
    cond  = 1'b0;
    while (!cond && guard < 4 * FRAME) begin
      step();
      guard++;
      cond = m_pend_full && ((m_n % FRAME) / SLOT == 2) && ((m_n % FRAME) % SLOT > BC);
    end
    chk("reset_setup_reached", 32'(cond), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_seg", 32'(seg), 32'd0);
    chk("rst_an", 32'(an), 32'd0);
    chk("rst_dp", 32'(dp), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run(FRAME + 5);
    lz_en = 1'b1;
    run(FRAME);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
